vec_int_ctrl: RTL and testbench

Vectored interrupt controller: the requesting end of the processor's vectored-interrupt interface. Collects external interrupt lines, applies a mask and fixed priority, raises `intr` to the 8-bit processor, and answers the processor's `inta` with a 4-bit vector, the program-counter width, that the processor loads as its next `pc`. It tracks in-service levels and releases them on end-of-interrupt. It sits beside the processor and memories in `top_mp`.

---
 rtl/vec_int_ctrl_pkg.sv | 15 +
 rtl/vec_int_ctrl_if.sv | 30 +++
 rtl/vec_int_ctrl_prio_enc_f.sv | 24 ++
 rtl/vec_int_ctrl.sv | 134 +++++++++++++
 tb/tb_vec_int_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_int_ctrl_pkg.sv
// Shared types and default sizing for the vectored interrupt controller.
// FSM encoding plus the default line count, vector width and vector base.
package vec_int_ctrl_pkg;

  localparam int unsigned NUM_IRQ_DEF  = 4;
  localparam int unsigned VEC_W_DEF    = 4;
  localparam int unsigned VEC_BASE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } vic_state_e;

endpackage

// File: rtl/vec_int_ctrl_if.sv
// Processor-facing bundle of the interrupt controller: request lines, mask write,
// inta/eoi handshake in; intr, vector strobe and in-service status out.
interface vec_int_ctrl_if
  import vec_int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF
) ();

  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_in;
  logic               inta;
  logic               eoi;
  logic               intr;
  logic [VEC_W-1:0]   vector;
  logic               vec_valid;
  logic [NUM_IRQ-1:0] isr;

  modport master (
    output irq, mask_we, mask_in, inta, eoi,
    input  intr, vector, vec_valid, isr
  );

  modport slave (
    input  irq, mask_we, mask_in, inta, eoi,
    output intr, vector, vec_valid, isr
  );

endinterface

// File: rtl/vec_int_ctrl_prio_enc_f.sv
// Combinational lowest-index priority encoder: found flag plus index of the
// lowest set bit (index 0 when nothing is set).
module prio_enc_f #(
  parameter  int unsigned W  = 4,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge-detected, masked, fixed-priority requests with
// in-service tracking; define VIC_NEST_EN to let higher levels preempt lower ones.
module vec_int_ctrl
  import vec_int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = NUM_IRQ_DEF,
  parameter int unsigned VEC_W    = VEC_W_DEF,
  parameter int unsigned VEC_BASE = VEC_BASE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  vec_int_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  vic_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               intr_q, intr_d;
  logic               vec_valid_q, vec_valid_d;
  logic [VEC_W-1:0]   vector_q, vector_d;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               isr_found;
  logic [IDX_W-1:0]   isr_idx;
  logic               eligible;
  logic               ack;

  assign irq_edge = bus.irq & ~irq_q;
  assign cand     = pending_q & ~mask_q;

  prio_enc_f #(.W(NUM_IRQ)) u_win_enc (
    .req   (cand),
    .found (win_found),
    .idx   (win_idx)
  );

  prio_enc_f #(.W(NUM_IRQ)) u_isr_enc (
    .req   (isr_q),
    .found (isr_found),
    .idx   (isr_idx)
  );

`ifdef VIC_NEST_EN
  assign eligible = win_found && (!isr_found || (isr_idx > win_idx));
`else
  assign eligible = win_found && !isr_found;
`endif

  // Eligibility is rechecked in REQ so a late mask or reset withdraws intr.
  always_comb begin
    state_d     = state_q;
    intr_d      = 1'b0;
    vec_valid_d = 1'b0;
    vector_d    = vector_q;
    ack         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          state_d = ST_REQ;
          intr_d  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!eligible) begin
          state_d = ST_IDLE;
        end else if (bus.inta) begin
          ack         = 1'b1;
          state_d     = ST_ACK;
          vec_valid_d = 1'b1;
          vector_d    = VEC_W'(VEC_BASE) + VEC_W'(win_idx);
        end else begin
          intr_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A fresh edge on the acknowledged line wins over the acknowledge clear.
  always_comb begin
    irq_d     = bus.irq;
    mask_d    = bus.mask_we ? bus.mask_in : mask_q;
    pend_clr  = ack ? (NUM_IRQ'(1) << win_idx) : '0;
    pending_d = (pending_q & ~pend_clr) | irq_edge;
    isr_d     = isr_q;
    if (bus.eoi && isr_found) begin
      isr_d[isr_idx] = 1'b0;
    end
    if (ack) begin
      isr_d[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      isr_q       <= '0;
      intr_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      vector_q    <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      isr_q       <= isr_d;
      intr_q      <= intr_d;
      vec_valid_q <= vec_valid_d;
      vector_q    <= vector_d;
    end
  end

  assign bus.intr      = intr_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vector    = vector_q;
  assign bus.isr       = isr_q;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Bench for vec_int_ctrl: directed scenarios plus randomized traffic checked against
// a line-level reference model; a second instance uses VEC_BASE=14 for wraparound.
module tb_vec_int_ctrl;
  import vec_int_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       inta;
  logic       eoi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_int_ctrl_if bus1 ();
  vec_int_ctrl_if bus2 ();

  assign bus1.irq = irq;  assign bus1.mask_we = mask_we; assign bus1.mask_in = mask_in;
  assign bus1.inta = inta; assign bus1.eoi = eoi;
  assign bus2.irq = irq;  assign bus2.mask_we = mask_we; assign bus2.mask_in = mask_in;
  assign bus2.inta = inta; assign bus2.eoi = eoi;

  vec_int_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  vec_int_ctrl #(.VEC_BASE(14)) u_dut14 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Reference model: per-line flags and the three-phase handshake as plain booleans.
  bit m_pend [4];
  bit m_isr  [4];
  bit m_mask [4];
  bit m_prev [4];
  bit m_intr;
  bit m_vv;
  int m_vec8;
  int m_vec14;

  function automatic logic [3:0] model_isr();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_isr[i];
    return r;
  endfunction

  function automatic void model_update();
    int w;
    int h;
    bit elig;
    bit take;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_isr[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
      end
      m_intr = 0; m_vv = 0; m_vec8 = 0; m_vec14 = 0;
      return;
    end
    w = -1;
    h = -1;
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && m_pend[i] && !m_mask[i]) w = i;
      if (h < 0 && m_isr[i]) h = i;
    end
`ifdef VIC_NEST_EN
    elig = (w >= 0) && (h < 0 || h > w);
`else
    elig = (w >= 0) && (h < 0);
`endif
    take = 0;
    if (m_vv) begin
      m_vv = 0;
      m_intr = 0;
    end else if (m_intr && elig && inta) begin
      take = 1;
      m_intr = 0;
      m_vv = 1;
      m_vec8  = (8 + w) % 16;
      m_vec14 = (14 + w) % 16;
    end else begin
      m_intr = elig;
    end
    if (eoi && h >= 0) m_isr[h] = 0;
    if (take) begin
      m_isr[w]  = 1;
      m_pend[w] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
      if (mask_we) m_mask[i] = mask_in[i];
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0; inta = 1'b0; eoi = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", bus1.intr); end
    n_checks++; if (bus1.vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vv: got %b want 0", bus1.vec_valid); end
    n_checks++; if (bus1.vector !== 4'd0) begin n_fail++; $display("FAIL reset_vector: got %0d want 0", bus1.vector); end
    n_checks++; if (bus1.isr !== 4'b0000) begin n_fail++; $display("FAIL reset_isr: got %b want 0000", bus1.isr); end
  endtask

  task automatic test_single();
    do_reset();
    irq = 4'b0100; cycle();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL single_intr_early: got %b want 0", bus1.intr); end
    irq = 4'b0000; cycle();
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL single_intr: got %b want 1", bus1.intr); end
    inta = 1'b1; cycle();
    n_checks++; if (bus1.vec_valid !== 1'b1) begin n_fail++; $display("FAIL single_vv: got %b want 1", bus1.vec_valid); end
    n_checks++; if (bus1.vector !== 4'd10) begin n_fail++; $display("FAIL single_vector: got %0d want 10", bus1.vector); end
    n_checks++; if (bus1.isr !== 4'b0100) begin n_fail++; $display("FAIL single_isr: got %b want 0100", bus1.isr); end
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL single_intr_ack: got %b want 0", bus1.intr); end
    inta = 1'b0; cycle();
    n_checks++; if (bus1.vec_valid !== 1'b0) begin n_fail++; $display("FAIL single_vv_drop: got %b want 0", bus1.vec_valid); end
    n_checks++; if (bus1.vector !== 4'd10) begin n_fail++; $display("FAIL single_vector_hold: got %0d want 10", bus1.vector); end
    eoi = 1'b1; cycle();
    eoi = 1'b0;
    n_checks++; if (bus1.isr !== 4'b0000) begin n_fail++; $display("FAIL single_eoi: got %b want 0000", bus1.isr); end
  endtask

  task automatic test_two_lines();
    do_reset();
    irq = 4'b1010; cycle();
    irq = 4'b0000; cycle();
    inta = 1'b1; cycle();
    n_checks++; if (bus1.vector !== 4'd9) begin n_fail++; $display("FAIL two_first_vector: got %0d want 9", bus1.vector); end
    n_checks++; if (bus2.vector !== 4'd15) begin n_fail++; $display("FAIL two_first_vector14: got %0d want 15", bus2.vector); end
    n_checks++; if (bus1.isr !== 4'b0010) begin n_fail++; $display("FAIL two_first_isr: got %b want 0010", bus1.isr); end
    inta = 1'b0; cycle();
    cycle();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL two_blocked: got %b want 0", bus1.intr); end
    eoi = 1'b1; cycle();
    eoi = 1'b0; cycle();
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL two_after_eoi: got %b want 1", bus1.intr); end
    inta = 1'b1; cycle();
    n_checks++; if (bus1.vector !== 4'd11) begin n_fail++; $display("FAIL two_second_vector: got %0d want 11", bus1.vector); end
    n_checks++; if (bus2.vector !== 4'd1) begin n_fail++; $display("FAIL vec_base14_wrap: got %0d want 1", bus2.vector); end
    n_checks++; if (bus1.isr !== 4'b1000) begin n_fail++; $display("FAIL two_second_isr: got %b want 1000", bus1.isr); end
    inta = 1'b0; cycle();
    eoi = 1'b1; cycle();
    eoi = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    mask_we = 1'b1; mask_in = 4'b1111; cycle();
    mask_we = 1'b0; mask_in = 4'b0000;
    irq = 4'b0001; cycle();
    irq = 4'b0000; cycle();
    cycle();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL mask_blocks: got %b want 0", bus1.intr); end
    mask_we = 1'b1; cycle();
    mask_we = 1'b0; cycle();
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL mask_release: got %b want 1", bus1.intr); end
    inta = 1'b1; cycle();
    n_checks++; if (bus1.vector !== 4'd8) begin n_fail++; $display("FAIL mask_vector: got %0d want 8", bus1.vector); end
    n_checks++; if (bus2.vector !== 4'd14) begin n_fail++; $display("FAIL mask_vector14: got %0d want 14", bus2.vector); end
    inta = 1'b0; cycle();
    eoi = 1'b1; cycle();
    eoi = 1'b0;
  endtask

  task automatic test_nest();
    do_reset();
    irq = 4'b0100; cycle();
    irq = 4'b0000; cycle();
    inta = 1'b1; cycle();
    inta = 1'b0; cycle();
    irq = 4'b0001; cycle();
    irq = 4'b0000; cycle();
`ifdef VIC_NEST_EN
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL nest_intr: got %b want 1", bus1.intr); end
    inta = 1'b1; cycle();
    n_checks++; if (bus1.isr !== 4'b0101) begin n_fail++; $display("FAIL nest_isr: got %b want 0101", bus1.isr); end
    n_checks++; if (bus1.vector !== 4'd8) begin n_fail++; $display("FAIL nest_vector: got %0d want 8", bus1.vector); end
    inta = 1'b0; cycle();
    eoi = 1'b1; cycle();
    n_checks++; if (bus1.isr !== 4'b0100) begin n_fail++; $display("FAIL nest_eoi_order: got %b want 0100", bus1.isr); end
    cycle();
    eoi = 1'b0;
`else
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL nonest_intr: got %b want 0", bus1.intr); end
    cycle();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL nonest_hold: got %b want 0", bus1.intr); end
    eoi = 1'b1; cycle();
    eoi = 1'b0; cycle();
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL nonest_after_eoi: got %b want 1", bus1.intr); end
    inta = 1'b1; cycle();
    n_checks++; if (bus1.isr !== 4'b0001) begin n_fail++; $display("FAIL nonest_isr: got %b want 0001", bus1.isr); end
    n_checks++; if (bus1.vector !== 4'd8) begin n_fail++; $display("FAIL nonest_vector: got %0d want 8", bus1.vector); end
    inta = 1'b0; cycle();
    eoi = 1'b1; cycle();
    eoi = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq = 4'b0100; cycle();
    irq = 4'b0000; cycle();
    rst = 1'b1; inta = 1'b1; cycle();
    n_checks++; if (bus1.intr !== 1'b0 || bus1.vec_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got intr=%b vv=%b want 0 0", bus1.intr, bus1.vec_valid); end
    n_checks++; if (bus1.vector !== 4'd0 || bus1.isr !== 4'b0000) begin n_fail++; $display("FAIL midrst_state: got vec=%0d isr=%b want 0 0000", bus1.vector, bus1.isr); end
    rst = 1'b0; cycle();
    n_checks++; if (bus1.vec_valid !== 1'b0 || bus1.intr !== 1'b0) begin n_fail++; $display("FAIL midrst_inta_ignored: got vv=%b intr=%b want 0 0", bus1.vec_valid, bus1.intr); end
    inta = 1'b0;
    rst = 1'b1; irq = 4'b0010; cycle();
    cycle();
    rst = 1'b0; cycle();
    n_checks++; if (bus1.intr !== 1'b0) begin n_fail++; $display("FAIL held_high_early: got %b want 0", bus1.intr); end
    cycle();
    n_checks++; if (bus1.intr !== 1'b1) begin n_fail++; $display("FAIL held_high_edge: got %b want 1", bus1.intr); end
    irq = 4'b0000; inta = 1'b1; cycle();
    n_checks++; if (bus1.vector !== 4'd9) begin n_fail++; $display("FAIL held_high_vector: got %0d want 9", bus1.vector); end
    inta = 1'b0; cycle();
    eoi = 1'b1; cycle();
    eoi = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      irq     = 4'($urandom);
      inta    = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 5) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
      cycle();
      n_checks++; if (bus1.intr !== m_intr) begin n_fail++; $display("FAIL rand_intr @%0d: got %b want %b", n, bus1.intr, m_intr); end
      n_checks++; if (bus1.vec_valid !== m_vv) begin n_fail++; $display("FAIL rand_vv @%0d: got %b want %b", n, bus1.vec_valid, m_vv); end
      n_checks++; if (bus1.vector !== 4'(m_vec8)) begin n_fail++; $display("FAIL rand_vector @%0d: got %0d want %0d", n, bus1.vector, m_vec8); end
      n_checks++; if (bus2.vector !== 4'(m_vec14)) begin n_fail++; $display("FAIL rand_vector14 @%0d: got %0d want %0d", n, bus2.vector, m_vec14); end
      n_checks++; if (bus1.isr !== model_isr()) begin n_fail++; $display("FAIL rand_isr @%0d: got %b want %b", n, bus1.isr, model_isr()); end
    end
    rst = 1'b0; irq = '0; inta = 1'b0; eoi = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_lines();
    test_mask();
    test_nest();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
